// File: rtl/tx_fifo_pkg.sv
// Shared definitions for the frame-aware transmit FIFO.
// Default geometry, the stored entry layout and the drop counter width.
package tx_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DROP_CNT_W     = 16;

   // One stored word: payload plus the end-of-frame marker.
   typedef struct packed {
      logic                      last;
      logic [DEF_DATA_WIDTH-1:0] data;
   } tx_entry_t;

   typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module tx_fifo_ram
   import tx_fifo_pkg::*;
#(
   parameter int WIDTH      = DEF_DATA_WIDTH + 1,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write port: store the word at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tx_frame_fifo.sv
// Store-and-forward transmit FIFO with frame commit/abort and FWFT read.
// Words become visible to the reader only once the frame's last word is
// written; an abort rolls the write pointer back to the last commit point.
// Optional build macro: TX_FIFO_DROP_STATS_EN adds a saturating drop_count
// output counting effective aborts and overflow events.
module tx_frame_fifo
   import tx_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   input  logic                  wr_abort,
   output logic                  full,
   output logic                  almost_full,
   output logic                  wr_overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_valid,
   output logic                  almost_empty,
   output logic                  frame_avail,
   output logic [ADDR_WIDTH:0]   count
`ifdef TX_FIFO_DROP_STATS_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_count
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH_V  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AFULL_V  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_V = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] commit_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic [ADDR_WIDTH:0] frame_cnt;
   logic [ADDR_WIDTH:0] vis_cnt;

   logic                wr_accept;
   logic                wr_commit;
   logic                rd_accept;
   logic                rd_frame_done;
   logic [DATA_WIDTH:0] ram_wdata;
   logic [DATA_WIDTH:0] ram_rdata;

   // Flags derive only from registered pointers, so no wr_* input reaches
   // the read side combinationally.
   assign count        = wr_ptr - rd_ptr;
   assign vis_cnt      = commit_ptr - rd_ptr;
   assign full         = (count == DEPTH_V);
   assign almost_full  = (count >= AFULL_V);
   assign rd_valid     = (vis_cnt != '0);
   assign almost_empty = (vis_cnt <= AEMPTY_V);
   assign frame_avail  = (frame_cnt != '0);

   // Abort wins over a same-cycle write; full is judged before the read.
   assign wr_accept     = wr_en && !full && !wr_abort;
   assign wr_commit     = wr_accept && wr_last;
   assign rd_accept     = rd_en && rd_valid;
   assign rd_frame_done = rd_accept && rd_last;

   assign ram_wdata = {wr_last, wr_data};
   assign rd_data   = ram_rdata[DATA_WIDTH-1:0];
   // Memory is never cleared, so the stored flag is masked when nothing is visible.
   assign rd_last   = rd_valid && ram_rdata[DATA_WIDTH];

   tx_fifo_ram #(
      .WIDTH      (DATA_WIDTH + 1),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_accept),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (ram_wdata),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   // Pointer update: write/commit/abort on the write side, pop on the read side.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
      end else begin
         if (wr_abort) begin
            wr_ptr <= commit_ptr;
         end else if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_last) begin
               commit_ptr <= wr_ptr + 1'b1;
            end
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Complete-frame count; a commit and a final-word pop in one cycle cancel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else begin
         case ({wr_commit, rd_frame_done})
            2'b10:   frame_cnt <= frame_cnt + 1'b1;
            2'b01:   frame_cnt <= frame_cnt - 1'b1;
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end

   // Overflow pulse, one cycle after a write attempt against a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_overflow <= 1'b0;
      end else begin
         wr_overflow <= wr_en && full;
      end
   end

`ifdef TX_FIFO_DROP_STATS_EN
   logic       abort_eff;
   logic       ovf_evt;
   logic [1:0] drop_inc;

   function automatic drop_cnt_t drop_sat_add(input drop_cnt_t a, input logic [1:0] b);
      logic [DROP_CNT_W:0] s;
      s = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
      return s[DROP_CNT_W] ? '1 : s[DROP_CNT_W-1:0];
   endfunction

   assign abort_eff = wr_abort && (wr_ptr != commit_ptr);
   assign ovf_evt   = wr_en && full;
   assign drop_inc  = {1'b0, abort_eff} + {1'b0, ovf_evt};

   // Saturating count of discarded frames and rejected writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else begin
         drop_count <= drop_sat_add(drop_count, drop_inc);
      end
   end
`endif

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Directed self-checking bench for tx_frame_fifo (default geometry 8 x 16).
module tb_tx_frame_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_last;
   logic       wr_abort;
   logic       full;
   logic       almost_full;
   logic       wr_overflow;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_last;
   logic       rd_valid;
   logic       almost_empty;
   logic       frame_avail;
   logic [4:0] count;
`ifdef TX_FIFO_DROP_STATS_EN
   logic [15:0] drop_count;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   tx_frame_fifo dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .wr_last      (wr_last),
      .wr_abort     (wr_abort),
      .full         (full),
      .almost_full  (almost_full),
      .wr_overflow  (wr_overflow),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_last      (rd_last),
      .rd_valid     (rd_valid),
      .almost_empty (almost_empty),
      .frame_avail  (frame_avail),
      .count        (count)
`ifdef TX_FIFO_DROP_STATS_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      wr_last  = 1'b0;
      wr_abort = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      wr_en   = 1'b1;
      wr_data = d;
      wr_last = l;
      tick();
      wr_en   = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else pass_cnt++;
      total_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_afull got %b exp 0", almost_full); else pass_cnt++;
      total_cnt++; if (wr_overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", wr_overflow); else pass_cnt++;
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else pass_cnt++;
      total_cnt++; if (rd_last !== 1'b0) $display("FAIL reset_rd_last got %b exp 0", rd_last); else pass_cnt++;
      total_cnt++; if (frame_avail !== 1'b0) $display("FAIL reset_frame_avail got %b exp 0", frame_avail); else pass_cnt++;
      total_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_aempty got %b exp 1", almost_empty); else pass_cnt++;
`ifdef TX_FIFO_DROP_STATS_EN
      total_cnt++; if (drop_count !== 16'd0) $display("FAIL reset_drop_count got %0d exp 0", drop_count); else pass_cnt++;
`endif
   endtask

   task automatic test_frame_visibility();
      do_reset();
      push(8'hA1, 1'b0);
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL vis_after_a1 rd_valid got %b exp 0", rd_valid); else pass_cnt++;
      push(8'hA2, 1'b0);
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL vis_after_a2 rd_valid got %b exp 0", rd_valid); else pass_cnt++;
      total_cnt++; if (count !== 5'd2) $display("FAIL vis_count2 got %0d exp 2", count); else pass_cnt++;
      total_cnt++; if (frame_avail !== 1'b0) $display("FAIL vis_no_frame got %b exp 0", frame_avail); else pass_cnt++;
      push(8'hA3, 1'b1);
      total_cnt++; if (rd_valid !== 1'b1) $display("FAIL vis_after_a3 rd_valid got %b exp 1", rd_valid); else pass_cnt++;
      total_cnt++; if (frame_avail !== 1'b1) $display("FAIL vis_frame_avail got %b exp 1", frame_avail); else pass_cnt++;
      total_cnt++; if (rd_data !== 8'hA1) $display("FAIL vis_word0 got %h exp a1", rd_data); else pass_cnt++;
      total_cnt++; if (rd_last !== 1'b0) $display("FAIL vis_last0 got %b exp 0", rd_last); else pass_cnt++;
      rd_en = 1'b1;
      tick();
      total_cnt++; if (rd_data !== 8'hA2) $display("FAIL vis_word1 got %h exp a2", rd_data); else pass_cnt++;
      total_cnt++; if (rd_last !== 1'b0) $display("FAIL vis_last1 got %b exp 0", rd_last); else pass_cnt++;
      tick();
      total_cnt++; if (rd_data !== 8'hA3) $display("FAIL vis_word2 got %h exp a3", rd_data); else pass_cnt++;
      total_cnt++; if (rd_last !== 1'b1) $display("FAIL vis_last2 got %b exp 1", rd_last); else pass_cnt++;
      tick();
      rd_en = 1'b0;
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL vis_drained rd_valid got %b exp 0", rd_valid); else pass_cnt++;
      total_cnt++; if (frame_avail !== 1'b0) $display("FAIL vis_drained frame_avail got %b exp 0", frame_avail); else pass_cnt++;
      total_cnt++; if (count !== 5'd0) $display("FAIL vis_drained count got %0d exp 0", count); else pass_cnt++;
   endtask

   task automatic test_abort();
      do_reset();
      push(8'h10, 1'b0);
      push(8'h11, 1'b0);
      total_cnt++; if (count !== 5'd2) $display("FAIL abort_pre_count got %0d exp 2", count); else pass_cnt++;
      // abort together with a would-be commit word: the word must be dropped
      wr_abort = 1'b1;
      wr_en    = 1'b1;
      wr_data  = 8'h12;
      wr_last  = 1'b1;
      tick();
      idle_inputs();
      total_cnt++; if (count !== 5'd0) $display("FAIL abort_count got %0d exp 0", count); else pass_cnt++;
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL abort_rd_valid got %b exp 0", rd_valid); else pass_cnt++;
      total_cnt++; if (frame_avail !== 1'b0) $display("FAIL abort_frame_avail got %b exp 0", frame_avail); else pass_cnt++;
      push(8'h20, 1'b1);
      // abort with nothing uncommitted leaves the stored frame alone
      wr_abort = 1'b1;
      tick();
      wr_abort = 1'b0;
      total_cnt++; if (count !== 5'd1) $display("FAIL abort_noop_count got %0d exp 1", count); else pass_cnt++;
      total_cnt++; if (rd_data !== 8'h20) $display("FAIL abort_read got %h exp 20", rd_data); else pass_cnt++;
      total_cnt++; if (rd_last !== 1'b1) $display("FAIL abort_read_last got %b exp 1", rd_last); else pass_cnt++;
`ifdef TX_FIFO_DROP_STATS_EN
      total_cnt++; if (drop_count !== 16'd1) $display("FAIL abort_drop_count got %0d exp 1", drop_count); else pass_cnt++;
`endif
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL abort_only_one rd_valid got %b exp 0", rd_valid); else pass_cnt++;
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         push(8'(i), 1'b1);
         total_cnt++;
         if (almost_full !== (i + 1 >= 12))
            $display("FAIL afull_at_%0d got %b exp %b", i + 1, almost_full, (i + 1 >= 12));
         else pass_cnt++;
      end
      total_cnt++; if (full !== 1'b1) $display("FAIL full_flag got %b exp 1", full); else pass_cnt++;
      total_cnt++; if (count !== 5'd16) $display("FAIL full_count got %0d exp 16", count); else pass_cnt++;
      total_cnt++; if (wr_overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", wr_overflow); else pass_cnt++;
      total_cnt++; if (almost_empty !== 1'b0) $display("FAIL full_aempty got %b exp 0", almost_empty); else pass_cnt++;
      push(8'hFF, 1'b1);
      total_cnt++; if (wr_overflow !== 1'b1) $display("FAIL ovf_pulse got %b exp 1", wr_overflow); else pass_cnt++;
      total_cnt++; if (count !== 5'd16) $display("FAIL ovf_count got %0d exp 16", count); else pass_cnt++;
      tick();
      total_cnt++; if (wr_overflow !== 1'b0) $display("FAIL ovf_single got %b exp 0", wr_overflow); else pass_cnt++;
`ifdef TX_FIFO_DROP_STATS_EN
      total_cnt++; if (drop_count !== 16'd1) $display("FAIL ovf_drop_count got %0d exp 1", drop_count); else pass_cnt++;
`endif
      for (int i = 0; i < 16; i++) begin
         total_cnt++;
         if (rd_data !== 8'(i)) $display("FAIL full_read_%0d got %h exp %h", i, rd_data, 8'(i)); else pass_cnt++;
         total_cnt++;
         if (almost_empty !== (16 - i <= 2))
            $display("FAIL aempty_vis_%0d got %b exp %b", 16 - i, almost_empty, (16 - i <= 2));
         else pass_cnt++;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL full_no_ff rd_valid got %b exp 0", rd_valid); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      wr_last = 1'b1;
      rd_en   = 1'b1;
      tick();
      idle_inputs();
      total_cnt++; if (count !== 5'd15) $display("FAIL simul_count got %0d exp 15", count); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL simul_full got %b exp 0", full); else pass_cnt++;
      total_cnt++; if (wr_overflow !== 1'b1) $display("FAIL simul_ovf got %b exp 1", wr_overflow); else pass_cnt++;
      total_cnt++; if (rd_data !== 8'h01) $display("FAIL simul_head got %h exp 01", rd_data); else pass_cnt++;

      do_reset();
      push(8'h30, 1'b1);
      // commit 0x31 while popping the final (only) word of frame 0x30
      wr_en   = 1'b1;
      wr_data = 8'h31;
      wr_last = 1'b1;
      rd_en   = 1'b1;
      tick();
      idle_inputs();
      total_cnt++; if (frame_avail !== 1'b1) $display("FAIL simul_fc_avail got %b exp 1", frame_avail); else pass_cnt++;
      total_cnt++; if (rd_data !== 8'h31) $display("FAIL simul_fc_head got %h exp 31", rd_data); else pass_cnt++;
      total_cnt++; if (count !== 5'd1) $display("FAIL simul_fc_count got %0d exp 1", count); else pass_cnt++;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      total_cnt++; if (frame_avail !== 1'b0) $display("FAIL simul_fc_final got %b exp 0", frame_avail); else pass_cnt++;
   endtask

   task automatic test_wraparound();
      logic [7:0] wd [256];
      logic       wl [256];
      int total, mwr, mcm, mrd, cyc;
      logic do_wr, do_rd;
      do_reset();
      total = 0;
      for (int f = 0; f < 40; f++) begin
         for (int k = 0; k < (f % 5) + 1; k++) begin
            wd[total] = 8'(total * 3 + 1);
            wl[total] = (k == (f % 5));
            total++;
         end
      end
      mwr = 0; mcm = 0; mrd = 0; cyc = 0;
      while (mrd < total && cyc < 2000) begin
         do_wr   = (mwr < total) && (mwr - mrd < 16);
         wr_en   = do_wr;
         wr_data = do_wr ? wd[mwr] : 8'h00;
         wr_last = do_wr ? wl[mwr] : 1'b0;
         rd_en   = ((cyc % 5) != 2);
         do_rd   = rd_en && (mcm > mrd);
         total_cnt++;
         if (rd_valid !== (mcm > mrd)) $display("FAIL wrap_rd_valid cyc %0d got %b exp %b", cyc, rd_valid, (mcm > mrd)); else pass_cnt++;
         if (do_rd) begin
            total_cnt++;
            if (rd_data !== wd[mrd] || rd_last !== wl[mrd])
               $display("FAIL wrap_data word %0d got %h/%b exp %h/%b", mrd, rd_data, rd_last, wd[mrd], wl[mrd]);
            else pass_cnt++;
         end
         tick();
         if (do_wr) begin
            if (wl[mwr]) mcm = mwr + 1;
            mwr++;
         end
         if (do_rd) mrd++;
         total_cnt++;
         if (count !== 5'(mwr - mrd)) $display("FAIL wrap_count cyc %0d got %0d exp %0d", cyc, count, mwr - mrd); else pass_cnt++;
         cyc++;
      end
      idle_inputs();
      total_cnt++;
      if (mrd != total) $display("FAIL wrap_timeout read %0d exp %0d", mrd, total); else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      do_reset();
      push(8'h40, 1'b1);
      push(8'h41, 1'b0);
      push(8'h42, 1'b0);
      total_cnt++; if (count !== 5'd3) $display("FAIL mid_pre_count got %0d exp 3", count); else pass_cnt++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total_cnt++; if (count !== 5'd0) $display("FAIL mid_count got %0d exp 0", count); else pass_cnt++;
      total_cnt++; if (rd_valid !== 1'b0) $display("FAIL mid_rd_valid got %b exp 0", rd_valid); else pass_cnt++;
      total_cnt++; if (frame_avail !== 1'b0) $display("FAIL mid_frame_avail got %b exp 0", frame_avail); else pass_cnt++;
      total_cnt++; if (almost_empty !== 1'b1) $display("FAIL mid_aempty got %b exp 1", almost_empty); else pass_cnt++;
      push(8'h50, 1'b1);
      total_cnt++; if (rd_data !== 8'h50) $display("FAIL mid_after_read got %h exp 50", rd_data); else pass_cnt++;
      total_cnt++; if (count !== 5'd1) $display("FAIL mid_after_count got %0d exp 1", count); else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_frame_visibility();
      test_abort();
      test_full_overflow();
      test_simultaneous();
      test_wraparound();
      test_reset_midframe();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
